vjtag_cmd_engine: RTL and testbench

//  Consumes the virtual-JTAG TAP strobes and IR value and implements the user data registers behind them.

---
 rtl/vjtag_cmd_engine.sv | 140 ++++++++++++++
 tb/tb_vjtag_cmd_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vjtag_cmd_engine.sv
// Virtual-JTAG user data registers: IDCODE, command write, status read,
// reset request and bypass, all clocked by tck.
module vjtag_cmd_engine #(
  parameter int          DATA_W     = 32,
  parameter logic [31:0] IDCODE     = 32'h5A5A_0001,
  parameter int          RST_CYCLES = 8
) (
  input  logic              tck,
  input  logic              reset_n,
  input  logic              tdi,
  output logic              tdo,
  input  logic [4:0]        ir_in,
  output logic [4:0]        ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_e1dr,
  input  logic              virtual_state_pdr,
  input  logic              virtual_state_e2dr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_cir,
  input  logic              virtual_state_uir,
  input  logic [DATA_W-1:0] status_in,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_valid,
  output logic [15:0]       cmd_count,
  output logic              rst_req
);

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_WRITE  = 5'h02;
  localparam logic [4:0] IR_STATUS = 5'h03;
  localparam logic [4:0] IR_RESET  = 5'h04;

  localparam logic [DATA_W-1:0] ID_VAL = DATA_W'(IDCODE);
  localparam logic [7:0]        RELOAD = 8'(RST_CYCLES - 1);

  typedef enum logic {
    R_IDLE,
    R_PULSE
  } rst_st_e;

  logic [DATA_W-1:0] dr;
  logic              byp;
  rst_st_e           state_q, state_d;
  logic [7:0]        ctr_q, ctr_d;

  logic is_id, is_wr, is_st, is_rs, is_byp;
  logic start;

  // Idle TAP states leave every register untouched.
  logic unused_ok;
  assign unused_ok = virtual_state_e1dr ^ virtual_state_pdr
                   ^ virtual_state_e2dr ^ virtual_state_uir;

  assign is_id  = (ir_in == IR_IDCODE);
  assign is_wr  = (ir_in == IR_WRITE);
  assign is_st  = (ir_in == IR_STATUS);
  assign is_rs  = (ir_in == IR_RESET);
  assign is_byp = !(is_id || is_wr || is_st || is_rs);

  assign tdo     = is_byp ? byp : dr[0];
  assign rst_req = (state_q == R_PULSE);
  assign start   = virtual_state_udr && is_rs && dr[0];

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      dr  <= '0;
      byp <= 1'b0;
    end else if (virtual_state_cdr) begin
      unique case (1'b1)
        is_id:  dr  <= ID_VAL;
        is_st:  dr  <= status_in;
        is_wr:  dr  <= cmd_data;
        is_rs:  dr  <= {{(DATA_W-1){1'b0}}, rst_req};
        is_byp: byp <= 1'b0;
      endcase
    end else if (virtual_state_sdr) begin
      if (is_byp)
        byp <= tdi;
      else
        dr <= {tdi, dr[DATA_W-1:1]};
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      cmd_count <= '0;
    end else begin
      cmd_valid <= virtual_state_udr && is_wr;
      if (virtual_state_udr && is_wr) begin
        cmd_data <= dr;
        if (cmd_count != 16'hFFFF)
          cmd_count <= cmd_count + 16'd1;
      end
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n)
      ir_out <= '0;
    else if (virtual_state_cir)
      ir_out <= {rst_req, cmd_count[3:0]};
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= R_IDLE;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // A fresh start while pulsing reloads the counter, stretching the pulse.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      R_IDLE: begin
        if (start) begin
          state_d = R_PULSE;
          ctr_d   = RELOAD;
        end
      end
      R_PULSE: begin
        if (start)
          ctr_d = RELOAD;
        else if (ctr_q == 8'd0)
          state_d = R_IDLE;
        else
          ctr_d = ctr_q - 8'd1;
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vjtag_cmd_engine.sv
// Directed bench for vjtag_cmd_engine: scan chains, writes,
// reset pulse timing, bypass, saturation and async reset.
module tb_vjtag_cmd_engine;

  logic        tck = 1'b0;
  logic        reset_n;
  logic        tdi;
  logic        tdo;
  logic [4:0]  ir_in;
  logic [4:0]  ir_out;
  logic        cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
  logic [31:0] status_in;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic [15:0] cmd_count;
  logic        rst_req;

  int n_run  = 0;
  int n_fail = 0;

  always #5 tck = ~tck;

  vjtag_cmd_engine dut (
    .tck                (tck),
    .reset_n            (reset_n),
    .tdi                (tdi),
    .tdo                (tdo),
    .ir_in              (ir_in),
    .ir_out             (ir_out),
    .virtual_state_cdr  (cdr),
    .virtual_state_sdr  (sdr),
    .virtual_state_e1dr (e1dr),
    .virtual_state_pdr  (pdr),
    .virtual_state_e2dr (e2dr),
    .virtual_state_udr  (udr),
    .virtual_state_cir  (cir),
    .virtual_state_uir  (uir),
    .status_in          (status_in),
    .cmd_data           (cmd_data),
    .cmd_valid          (cmd_valid),
    .cmd_count          (cmd_count),
    .rst_req            (rst_req)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge tck);
  endtask

  // Capture tdo before each shift edge, shifting v in LSB-first.
  task automatic shift(input logic [31:0] v, input int n,
                       output logic [31:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got[i] = tdo;
      tdi = v[i];
      sdr = 1'b1;
      tick();
    end
    sdr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic strobe_cdr();
    cdr = 1'b1;
    tick();
    cdr = 1'b0;
  endtask

  task automatic strobe_udr();
    udr = 1'b1;
    tick();
    udr = 1'b0;
  endtask

  task automatic strobe_cir();
    cir = 1'b1;
    tick();
    cir = 1'b0;
  endtask

  logic [31:0] got;
  int n;

  initial begin
    reset_n = 1'b0;
    tdi = 0; ir_in = 5'h00; status_in = '0;
    cdr = 0; sdr = 0; e1dr = 0; pdr = 0; e2dr = 0;
    udr = 0; cir = 0; uir = 0;
    tick(); tick();
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_outs", {cmd_data}, 32'd0);
    chk("rst_misc", {10'd0, ir_out, cmd_count, cmd_valid}, 32'd0);
    chk("rst_req0", 32'(rst_req), 32'd0);
    reset_n = 1'b1;
    tick();

    // IDCODE scan-out
    ir_in = 5'h01;
    strobe_cdr();
    shift(32'h0, 32, got);
    chk("idcode", got, 32'h5A5A_0001);
    chk("id_dr_end", 32'(tdo), 32'd0);

    // Command write
    ir_in = 5'h02;
    strobe_cdr();
    shift(32'hDEAD_BEEF, 32, got);
    chk("wr_valid_pre", 32'(cmd_valid), 32'd0);
    strobe_udr();
    chk("wr_data", cmd_data, 32'hDEAD_BEEF);
    chk("wr_valid", 32'(cmd_valid), 32'd1);
    chk("wr_count", 32'(cmd_count), 32'd1);
    tick();
    chk("wr_valid_off", 32'(cmd_valid), 32'd0);

    // Status read, then a discarded update
    ir_in = 5'h03;
    status_in = 32'h0000_00A5;
    strobe_cdr();
    shift(32'h0, 8, got);
    chk("status", got, 32'h0000_00A5);
    strobe_udr();
    chk("st_valid", 32'(cmd_valid), 32'd0);
    chk("st_data", cmd_data, 32'hDEAD_BEEF);
    chk("st_count", 32'(cmd_count), 32'd1);

    // Reset request with dr[0]=0 is ignored
    ir_in = 5'h04;
    strobe_cdr();
    shift(32'h0, 32, got);
    strobe_udr();
    chk("rs_ignore", 32'(rst_req), 32'd0);

    // Reset pulse width
    shift(32'hFFFF_FFFF, 32, got);
    strobe_udr();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (rst_req) n++;
      tick();
    end
    chk("rs_width", 32'(n), 32'd8);

    // Re-trigger during 5th high cycle extends the pulse
    strobe_udr();
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (rst_req) n++;
      udr = (c == 4);
      tick();
    end
    udr = 1'b0;
    chk("rs_retrig", 32'(n), 32'd13);
    chk("rs_end", 32'(rst_req), 32'd0);

    // ir_out capture while pulsing, and IR change does not abort
    strobe_udr();
    ir_in = 5'h1F;
    strobe_cir();
    chk("ir_out_pulse", 32'(ir_out), 32'h11);
    chk("rs_ir_change", 32'(rst_req), 32'd1);
    repeat (10) tick();
    chk("ir_out_hold", 32'(ir_out), 32'h11);

    // Bypass: one-cycle delay through byp
    strobe_cdr();
    shift(32'hD, 4, got);
    chk("bypass", got[3:0], 32'hA);
    chk("byp_last", 32'(tdo), 32'd1);

    // Saturating write counter
    ir_in = 5'h02;
    udr = 1'b1;
    repeat (65534) tick();
    udr = 1'b0;
    chk("cnt_max", 32'(cmd_count), 32'hFFFF);
    strobe_udr();
    chk("cnt_sat", 32'(cmd_count), 32'hFFFF);
    chk("sat_valid", 32'(cmd_valid), 32'd1);

    // Async reset mid-shift
    ir_in = 5'h01;
    strobe_cdr();
    shift(32'h0, 3, got);
    sdr = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("ars_shift", {cmd_data}, 32'd0);
    chk("ars_sh_misc",
        {10'd0, ir_out, cmd_count, cmd_valid}, 32'd0);
    chk("ars_sh_tdo", 32'(tdo), 32'd0);
    sdr = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Async reset mid-pulse
    ir_in = 5'h04;
    shift(32'hFFFF_FFFF, 32, got);
    strobe_udr();
    chk("ars_pre", 32'(rst_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ars_pulse", 32'(rst_req), 32'd0);
    chk("ars_tdo", 32'(tdo), 32'd0);
    tick();
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rst_req || cmd_valid) n++;
    end
    chk("ars_noglitch", 32'(n), 32'd0);
    strobe_cir();
    chk("ars_ir_out", 32'(ir_out), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
